// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - framebuffer RAM arbiter with double-buffered display line fetch
module vram_arbiter #(
  parameter logic [15:0] BASE_ADDR      = 16'h0200,
  parameter int          COLS           = 32,
  parameter int          CPU_SLOT_EVERY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        line_req,
  input  logic [4:0]  line_row,
  input  logic        swap,
  input  logic [4:0]  disp_col,
  output logic [7:0]  disp_data,
  output logic        line_busy,
  output logic        line_done,
  output logic        overrun,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int COL_W = $clog2(COLS);
  localparam int RUN_W = $clog2(CPU_SLOT_EVERY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       row_q;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] cap_col_q;
  logic [RUN_W-1:0] run_q;
  logic             front_q;
  logic             cap_valid_q;
  logic             ack_q;
  logic             done_q;
  logic             overrun_q;
  logic [15:0]      addr_hold_q;
  logic [15:0]      fetch_addr;
  logic             cpu_grant;
  logic             fetch_slot;
  logic             accept_line;
  logic             accept_swap;
  logic             last_col;
  logic             run_full;
  logic [7:0]       bank_q [2][COLS];

  assign last_col   = (col_q == COL_W'(COLS - 1));
  assign run_full   = (run_q == RUN_W'(CPU_SLOT_EVERY));
  assign fetch_addr = BASE_ADDR + 16'(row_q) * 16'(COLS) + 16'(col_q);

  // Slot owner for this cycle and next FSM state; the fetch beats the CPU
  // except when the run of fetch slots is full, and the ack cycle never
  // grants so a request still held through its ack is not serviced twice.
  always_comb begin
    state_d     = state_q;
    cpu_grant   = 1'b0;
    fetch_slot  = 1'b0;
    accept_line = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_req) begin
          accept_line = 1'b1;
          state_d     = FETCH;
        end else if (cpu_req && !ack_q) begin
          cpu_grant = 1'b1;
        end
      end
      FETCH: begin
        if (cpu_req && !ack_q && run_full) begin
          cpu_grant = 1'b1;
        end else begin
          fetch_slot = 1'b1;
          if (last_col) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign line_busy   = (state_q != IDLE);
  assign accept_swap = swap && !line_busy;

  // RAM port is driven in the slot's own cycle; idle slots repeat the last address
  assign mem_addr  = cpu_grant ? cpu_addr : (fetch_slot ? fetch_addr : addr_hold_q);
  assign mem_we    = cpu_grant & cpu_we;
  assign mem_wdata = (cpu_grant & cpu_we) ? cpu_wdata : 8'h00;

  assign cpu_ack   = ack_q;
  assign cpu_rdata = ack_q ? mem_rdata : 8'h00;
  assign line_done = done_q;
  assign overrun   = overrun_q;
  assign disp_data = bank_q[front_q][disp_col];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Row latch, column counter and consecutive-fetch run counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
      run_q <= '0;
    end else if (accept_line) begin
      row_q <= line_row;
      col_q <= '0;
      run_q <= '0;
    end else if (fetch_slot) begin
      col_q <= last_col ? '0 : col_q + COL_W'(1);
      run_q <= run_full ? run_q : run_q + RUN_W'(1);
    end else if (cpu_grant) begin
      run_q <= '0;
    end
  end

  // Read-return tracking, CPU ack, completion pulse, error flag, bank select
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid_q <= 1'b0;
      cap_col_q   <= '0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      front_q     <= 1'b0;
      addr_hold_q <= '0;
    end else begin
      cap_valid_q <= fetch_slot;
      cap_col_q   <= col_q;
      ack_q       <= cpu_grant;
      done_q      <= (state_q == DRAIN);
      addr_hold_q <= mem_addr;
      if ((line_req || swap) && line_busy) begin
        overrun_q <= 1'b1;
      end
      if (accept_swap) begin
        front_q <= ~front_q;
      end
    end
  end

  // Line buffer: returning fetch data lands in the back bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < COLS; c++) begin
          bank_q[b][c] <= 8'h00;
        end
      end
    end else if (cap_valid_q) begin
      bank_q[~front_q][cap_col_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        line_req;
  logic [4:0]  line_row;
  logic        swap;
  logic [4:0]  disp_col;
  logic [7:0]  disp_data;
  logic        line_busy, line_done, overrun;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [65536];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, done_cyc, ack_cyc, first_cpu_cyc, n_ack;
  logic        hold_mode;
  logic [15:0] watch_addr, prev_addr;
  logic [15:0] fetch_q [$];
  logic [7:0]  line_q  [$];
  logic [8:0]  ack_q   [$];

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .line_req  (line_req),
    .line_row  (line_row),
    .swap      (swap),
    .disp_col  (disp_col),
    .disp_data (disp_data),
    .line_busy (line_busy),
    .line_done (line_done),
    .overrun   (overrun),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // single-port RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ {a[10:8], 5'b00000};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic sample();
    logic [15:0] ea;
    logic [8:0]  ev;
    if (fetch_q.size() > 0 && !mem_we && mem_addr >= 16'h0200 && mem_addr <= 16'h05FF
        && mem_addr != prev_addr) begin
      ea = fetch_q.pop_front();
      check("fetch_addr", 32'(mem_addr), 32'(ea));
    end
    prev_addr = mem_addr;
    if (mem_addr == watch_addr && first_cpu_cyc < 0) first_cpu_cyc = cyc;
    if (cpu_ack) begin
      n_ack++;
      if (ack_cyc < 0) ack_cyc = cyc;
      if (hold_mode) begin
        check("hold_rdata", 32'(cpu_rdata), 32'(pat(16'h0700)));
      end else if (ack_q.size() == 0) begin
        check("spurious_ack", 32'(cpu_ack), 32'(0));
      end else begin
        ev = ack_q.pop_front();
        if (ev[8]) check("cpu_rdata", 32'(cpu_rdata), 32'(ev[7:0]));
      end
    end
    if (line_done && done_cyc < 0) begin
      done_cyc = cyc;
      check("busy_at_done", 32'(line_busy), 32'(0));
      check("fetch_q_empty", 32'(fetch_q.size()), 32'(0));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_line(input logic [4:0] row, input logic push_disp);
    logic [15:0] a;
    line_row = row;
    line_req = 1'b1;
    for (int c = 0; c < 32; c++) begin
      a = 16'h0200 + 16'(row) * 16'd32 + 16'(c);
      fetch_q.push_back(a);
      if (push_disp) line_q.push_back(pat(a));
    end
    done_cyc = -1; ack_cyc = -1; first_cpu_cyc = -1; n_ack = 0;
    cyc = -1;
    tick();
    line_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc < 0; i++) tick();
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] d);
    cpu_we = we; cpu_addr = addr; cpu_wdata = d; cpu_req = 1'b1;
    ack_q.push_back({~we, d});
    ack_cyc = -1; n_ack = 0; cyc = 0;
    for (int i = 0; i < 10 && ack_cyc < 0; i++) tick();
    cpu_req = 1'b0;
    tick();
    tick();
    check("cpu_latency", 32'(ack_cyc), 32'(1));
    check("cpu_ack_count", 32'(n_ack), 32'(1));
  endtask

  task automatic check_front();
    for (int c = 0; c < 32; c++) begin
      disp_col = 5'(c);
      #1;
      check("disp_data", 32'(disp_data), 32'(line_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    line_req = 1'b0; line_row = '0; swap = 1'b0; disp_col = '0;
    hold_mode = 1'b0; watch_addr = 16'h0700; prev_addr = '0;
    cyc = 0; done_cyc = -1; ack_cyc = -1; first_cpu_cyc = -1; n_ack = 0;
    tick();
    tick();
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_busy", 32'(line_busy), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    check("rst_disp", 32'(disp_data), 32'(0));
    reset_n = 1'b1;
    tick();

    // uncontended fetch of row 3, swap, read front bank
    start_line(5'd3, 1'b1);
    check("busy_rise", 32'(line_busy), 32'(1));
    wait_done(60);
    check("done_latency_plain", 32'(done_cyc), 32'(33));
    swap = 1'b1;
    tick();
    swap = 1'b0;
    disp_col = 5'd5;
    #1;
    check("disp_col5", 32'(disp_data), 32'(pat(16'h0265)));
    check_front();

    // idle CPU write then read back
    cpu_access(1'b1, 16'h0300, 8'h07);
    cpu_access(1'b0, 16'h0300, 8'h07);

    // CPU request held across a fetch
    start_line(5'd1, 1'b0);
    hold_mode = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0700; cpu_req = 1'b1;
    wait_done(80);
    check("hold_first_cpu_slot", 32'(first_cpu_cyc), 32'(4));
    check("hold_acks_in_fetch", 32'(n_ack), 32'(7));
    check("hold_done_latency", 32'(done_cyc), 32'(40));
    cpu_req = 1'b0;
    tick();
    tick();
    check("hold_acks_total", 32'(n_ack), 32'(8));
    hold_mode = 1'b0;

    // line_req and cpu_req in the same idle cycle
    cpu_we = 1'b0; cpu_addr = 16'h0701; cpu_req = 1'b1;
    ack_q.push_back({1'b1, pat(16'h0701)});
    start_line(5'd0, 1'b0);
    for (int i = 0; i < 80 && done_cyc < 0; i++) begin
      tick();
      if (ack_cyc >= 0) cpu_req = 1'b0;
    end
    check("tie_ack_cycle", 32'(ack_cyc), 32'(5));
    check("tie_done_latency", 32'(done_cyc), 32'(34));
    check("tie_ack_q_empty", 32'(ack_q.size()), 32'(0));

    // line_req and swap while busy are ignored; swap on line_done is taken
    check("overrun_pre", 32'(overrun), 32'(0));
    start_line(5'd2, 1'b1);
    for (int i = 0; i < 80 && done_cyc < 0; i++) begin
      if (cyc == 10) begin line_req = 1'b1; line_row = 5'd9; end
      if (cyc == 12) swap = 1'b1;
      if (cyc == 14) begin
        disp_col = 5'd5;
        #1;
        check("front_kept", 32'(disp_data), 32'(pat(16'h0265)));
        check("overrun_set", 32'(overrun), 32'(1));
      end
      if (cyc == 33) swap = 1'b1;
      tick();
      line_req = 1'b0;
      swap = 1'b0;
    end
    check("ovr_done_latency", 32'(done_cyc), 32'(33));
    check("overrun_sticky", 32'(overrun), 32'(1));
    check_front();

    // asynchronous reset at fetch column 10
    start_line(5'd4, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    disp_col = 5'd5;
    #1;
    check("ar_busy", 32'(line_busy), 32'(0));
    check("ar_overrun", 32'(overrun), 32'(0));
    check("ar_mem", {14'h0, mem_we, cpu_ack, mem_addr}, 32'(0));
    check("ar_wdata", {cpu_rdata, mem_wdata, 8'h00, disp_data}, 32'(0));
    disp_col = 5'd20;
    #1;
    check("ar_disp20", 32'(disp_data), 32'(0));
    fetch_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("ar_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    start_line(5'd5, 1'b1);
    wait_done(60);
    check("ar_restart_latency", 32'(done_cyc), 32'(33));
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check_front();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
